// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-port register file: default widths and
// the write-merge helper that picks the winning write port for an index.
package regfile_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int ADDR_W_DEF = 5;

   // Widest write-port count the merge helper resolves; callers zero-extend.
   localparam int N_WR_MAX = 2;
   localparam int WP_W     = $clog2(N_WR_MAX);

   typedef logic [WP_W-1:0] wr_port_t;

   // Result of merging all write ports against one register index.
   typedef struct packed {
      logic     hit;   // some write port targets the index this cycle
      wr_port_t port;  // winning port when hit is set
   } wr_sel_t;

   // match[w] = write port w is enabled and addresses the index of interest.
   // Ascending scan with overwrite, so the highest-numbered match wins.
   function automatic wr_sel_t wr_merge(input logic [N_WR_MAX-1:0] match);
      wr_sel_t sel;
      sel = '0;
      for (int w = 0; w < N_WR_MAX; w++) begin
         if (match[w]) begin
            sel.hit  = 1'b1;
            sel.port = wr_port_t'(w);
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// One registered read port: write-first bypass of data and pending state,
// register-0 masking, and the output registers.
module regfile_rd_port
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int N_WR     = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rd_en,
   input  logic [ADDR_W-1:0]      rd_addr,
   input  logic [XLEN-1:0]        rf_data,
   input  logic                   rf_pend,
   input  logic [N_WR-1:0]        wr_en,
   input  logic [N_WR*ADDR_W-1:0] wr_addr,
   input  logic [N_WR*XLEN-1:0]   wr_data,
   input  logic                   pend_set,
   input  logic [ADDR_W-1:0]      pend_addr,
   output logic [XLEN-1:0]        rd_data,
   output logic                   rd_valid,
   output logic                   rd_pend
);

   logic [N_WR_MAX-1:0] match;
   wr_sel_t             sel;
   logic [XLEN-1:0]     data_d, data_q;
   logic                pend_d, pend_q;
   logic                valid_q;

   // Write-first view of the addressed register: bypassed data, pending bit.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a value unassigned and no latch is inferred.
      match  = '0;
      data_d = rf_data;
      pend_d = rf_pend;
      for (int w = 0; w < N_WR; w++) begin
         match[w] = wr_en[w] && (wr_addr[w*ADDR_W +: ADDR_W] == rd_addr);
      end
      sel = wr_merge(match);
      if (sel.hit) begin
         data_d = wr_data[int'(sel.port)*XLEN +: XLEN];
         pend_d = 1'b0;
      end
      // A same-cycle set beats a same-cycle write clear.
      if (pend_set && (pend_addr == rd_addr)) begin
         pend_d = 1'b1;
      end
      if ((ZERO_REG != 0) && (rd_addr == '0)) begin
         data_d = '0;
         pend_d = 1'b0;
      end
   end

   // Output registers: capture on a read, otherwise hold data/pend and drop valid.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (!rst) begin
         data_q  <= '0;
         pend_q  <= 1'b0;
         valid_q <= 1'b0;
      end else if (rd_en) begin
         data_q  <= data_d;
         pend_q  <= pend_d;
         valid_q <= 1'b1;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign rd_data  = data_q;
   assign rd_pend  = pend_q;
   assign rd_valid = valid_q;

endmodule

// File: rtl/regfile_nr_mw.sv
// Multi-read / multi-write register file with per-register pending
// (awaiting writeback) bits and write-first bypass on every read port.
module regfile_nr_mw
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int N_RD     = 2,
   parameter int N_WR     = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_RD-1:0]        rd_en,
   input  logic [N_RD*ADDR_W-1:0] rd_addr,
   output logic [N_RD*XLEN-1:0]   rd_data,
   output logic [N_RD-1:0]        rd_valid,
   output logic [N_RD-1:0]        rd_pend,
   input  logic [N_WR-1:0]        wr_en,
   input  logic [N_WR*ADDR_W-1:0] wr_addr,
   input  logic [N_WR*XLEN-1:0]   wr_data,
   input  logic                   pend_set,
   input  logic [ADDR_W-1:0]      pend_addr
);

   localparam int DEPTH = 1 << ADDR_W;

   // Storage kept as one array so it can be swapped for an SRAM macro;
   // all forwarding lives in the read ports.
   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [DEPTH-1:0] pend_q;

   // Commit writes and pending updates; register 0 is frozen when ZERO_REG.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the array is reset on purpose: clearing every register on
         // reset is architectural here, so an SRAM replacement must supply
         // an equivalent clear sequence.
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         pend_q <= '0;
      end else begin
         // Ascending port order: the last scheduled update to an entry
         // takes effect, so the higher-numbered port wins a collision.
         for (int w = 0; w < N_WR; w++) begin
            if (wr_en[w] && ((ZERO_REG == 0) || (wr_addr[w*ADDR_W +: ADDR_W] != '0))) begin
               mem_q[wr_addr[w*ADDR_W +: ADDR_W]]  <= wr_data[w*XLEN +: XLEN];
               pend_q[wr_addr[w*ADDR_W +: ADDR_W]] <= 1'b0;
            end
         end
         // Placed after the write clears so a same-cycle set wins.
         if (pend_set && ((ZERO_REG == 0) || (pend_addr != '0))) begin
            pend_q[pend_addr] <= 1'b1;
         end
      end
   end

   for (genvar p = 0; p < N_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [XLEN-1:0]   rf_data;
      logic              rf_pend;

      assign addr    = rd_addr[p*ADDR_W +: ADDR_W];
      assign rf_data = mem_q[addr];
      assign rf_pend = pend_q[addr];

      regfile_rd_port #(
         .XLEN     (XLEN),
         .ADDR_W   (ADDR_W),
         .N_WR     (N_WR),
         .ZERO_REG (ZERO_REG)
      ) u_rd_port (
         .clk       (clk),
         .rst       (rst),
         .rd_en     (rd_en[p]),
         .rd_addr   (addr),
         .rf_data   (rf_data),
         .rf_pend   (rf_pend),
         .wr_en     (wr_en),
         .wr_addr   (wr_addr),
         .wr_data   (wr_data),
         .pend_set  (pend_set),
         .pend_addr (pend_addr),
         .rd_data   (rd_data[p*XLEN +: XLEN]),
         .rd_valid  (rd_valid[p]),
         .rd_pend   (rd_pend[p])
      );
   end

endmodule

// File: tb/tb_regfile_nr_mw.sv
// Directed self-checking bench for regfile_nr_mw with two read and two
// write ports and register 0 hard-wired to zero.
module tb_regfile_nr_mw;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;
   localparam int N_RD   = 2;
   localparam int N_WR   = 2;

   logic                   clk;
   logic                   rst;
   logic [N_RD-1:0]        rd_en;
   logic [N_RD*ADDR_W-1:0] rd_addr;
   logic [N_RD*XLEN-1:0]   rd_data;
   logic [N_RD-1:0]        rd_valid;
   logic [N_RD-1:0]        rd_pend;
   logic [N_WR-1:0]        wr_en;
   logic [N_WR*ADDR_W-1:0] wr_addr;
   logic [N_WR*XLEN-1:0]   wr_data;
   logic                   pend_set;
   logic [ADDR_W-1:0]      pend_addr;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_nr_mw #(
      .XLEN     (XLEN),
      .ADDR_W   (ADDR_W),
      .N_RD     (N_RD),
      .N_WR     (N_WR),
      .ZERO_REG (1)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .rd_pend   (rd_pend),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .pend_set  (pend_set),
      .pend_addr (pend_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      rd_en     = '0;
      rd_addr   = '0;
      wr_en     = '0;
      wr_addr   = '0;
      wr_data   = '0;
      pend_set  = 1'b0;
      pend_addr = '0;
   endtask

   // Advance past the next rising edge; outputs are then stable for checking.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input int w, input logic [ADDR_W-1:0] a, input logic [XLEN-1:0] d);
      wr_en[w]                  = 1'b1;
      wr_addr[w*ADDR_W +: ADDR_W] = a;
      wr_data[w*XLEN +: XLEN]     = d;
   endtask

   task automatic rd(input int p, input logic [ADDR_W-1:0] a);
      rd_en[p]                    = 1'b1;
      rd_addr[p*ADDR_W +: ADDR_W] = a;
   endtask

   task automatic pset(input logic [ADDR_W-1:0] a);
      pend_set  = 1'b1;
      pend_addr = a;
   endtask

   function automatic logic [31:0] rdat(input int p);
      return rd_data[p*XLEN +: XLEN];
   endfunction

   function automatic logic [31:0] pat(input int i);
      return 32'hC0DE_0000 + (32'(i) << 8) + 32'(i);
   endfunction

   initial begin
      idle();
      rst = 1'b0;
      repeat (2) tick();
      check("rst_valid", 32'(rd_valid), 32'h0);
      check("rst_data0", rdat(0), 32'h0);
      check("rst_data1", rdat(1), 32'h0);
      check("rst_pend", 32'(rd_pend), 32'h0);

      // Requests presented while reset is held are discarded.
      wr(0, 5'd6, 32'h0000_6666);
      pset(5'd6);
      rd(0, 5'd6);
      tick();
      check("rst_req_valid", 32'(rd_valid), 32'h0);

      // Release reset with a write pending: the first high edge takes it.
      idle();
      rst = 1'b1;
      wr(0, 5'd4, 32'h0000_0044);
      tick();
      idle();
      rd(0, 5'd4);
      rd(1, 5'd6);
      tick();
      check("rel_wr_x4", rdat(0), 32'h0000_0044);
      check("disc_wr_x6", rdat(1), 32'h0);
      check("disc_pend_x6", 32'(rd_pend[1]), 32'h0);
      check("rel_valid", 32'(rd_valid), 32'h3);

      // Plain write then read one cycle later.
      idle();
      wr(0, 5'd5, 32'hDEAD_BEEF);
      tick();
      idle();
      rd(0, 5'd5);
      tick();
      check("x5_data", rdat(0), 32'hDEAD_BEEF);
      check("x5_valid", 32'(rd_valid), 32'h1);
      idle();
      tick();
      check("idle_valid", 32'(rd_valid), 32'h0);
      check("idle_hold", rdat(0), 32'hDEAD_BEEF);

      // Same-cycle write and read on both ports: bypass.
      idle();
      wr(0, 5'd7, 32'h0000_1234);
      rd(0, 5'd7);
      rd(1, 5'd7);
      tick();
      check("byp_x7_p0", rdat(0), 32'h0000_1234);
      check("byp_x7_p1", rdat(1), 32'h0000_1234);
      check("byp_x7_valid", 32'(rd_valid), 32'h3);

      // Two write ports to one index: port 1 wins in storage and bypass.
      idle();
      wr(0, 5'd3, 32'h0000_000A);
      wr(1, 5'd3, 32'h0000_000B);
      tick();
      idle();
      rd(0, 5'd3);
      tick();
      check("wcol_store", rdat(0), 32'h0000_000B);
      idle();
      wr(0, 5'd3, 32'h0000_000C);
      wr(1, 5'd3, 32'h0000_000D);
      rd(1, 5'd3);
      tick();
      check("wcol_byp", rdat(1), 32'h0000_000D);
      idle();
      rd(0, 5'd3);
      tick();
      check("wcol_store2", rdat(0), 32'h0000_000D);

      // Pending bits.
      idle();
      pset(5'd9);
      tick();
      idle();
      rd(0, 5'd9);
      tick();
      check("pend_x9_set", 32'(rd_pend[0]), 32'h1);
      idle();
      wr(0, 5'd9, 32'h0000_0099);
      pset(5'd9);
      rd(1, 5'd9);
      tick();
      check("pend_setwin_byp", 32'(rd_pend[1]), 32'h1);
      check("pend_setwin_data", rdat(1), 32'h0000_0099);
      idle();
      rd(0, 5'd9);
      tick();
      check("pend_setwin_store", 32'(rd_pend[0]), 32'h1);
      idle();
      wr(1, 5'd9, 32'h0000_0999);
      rd(0, 5'd9);
      tick();
      check("pend_clr_byp", 32'(rd_pend[0]), 32'h0);
      check("pend_clr_data", rdat(0), 32'h0000_0999);
      idle();
      rd(1, 5'd9);
      tick();
      check("pend_clr_store", 32'(rd_pend[1]), 32'h0);
      idle();
      pset(5'd10);
      rd(0, 5'd10);
      tick();
      check("pend_set_byp", 32'(rd_pend[0]), 32'h1);

      // Register 0 ignores writes and pending sets, also under bypass.
      idle();
      wr(0, 5'd0, 32'h0000_FFFF);
      wr(1, 5'd0, 32'h0000_FFFF);
      pset(5'd0);
      rd(0, 5'd0);
      tick();
      check("x0_byp_data", rdat(0), 32'h0);
      check("x0_byp_pend", 32'(rd_pend[0]), 32'h0);
      idle();
      rd(1, 5'd0);
      tick();
      check("x0_store_data", rdat(1), 32'h0);
      check("x0_store_pend", 32'(rd_pend[1]), 32'h0);

      // Fill x1..x31, then reset mid-stream.
      for (int i = 1; i < 32; i += 2) begin
         idle();
         wr(0, 5'(i), pat(i));
         if (i + 1 < 32) wr(1, 5'(i + 1), pat(i + 1));
         tick();
      end
      idle();
      pset(5'd12);
      tick();
      idle();
      rd(0, 5'd31);
      rd(1, 5'd1);
      tick();
      check("fill_x31", rdat(0), pat(31));
      check("fill_x1", rdat(1), pat(1));
      idle();
      rd(0, 5'd12);
      rd(1, 5'd30);
      tick();
      check("fill_pend_x12", 32'(rd_pend[0]), 32'h1);
      check("fill_x30", rdat(1), pat(30));
      check("fill_valid", 32'(rd_valid), 32'h3);

      idle();
      rd(0, 5'd31);
      rd(1, 5'd12);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("mid_rst_valid", 32'(rd_valid), 32'h0);
      check("mid_rst_data0", rdat(0), 32'h0);
      check("mid_rst_data1", rdat(1), 32'h0);
      check("mid_rst_pend", 32'(rd_pend), 32'h0);
      tick();
      check("mid_rst_edge_valid", 32'(rd_valid), 32'h0);
      idle();
      rst = 1'b1;
      tick();
      check("post_rst_no_stale", 32'(rd_valid), 32'h0);
      idle();
      rd(0, 5'd31);
      rd(1, 5'd12);
      tick();
      check("post_rst_x31", rdat(0), 32'h0);
      check("post_rst_x12", rdat(1), 32'h0);
      check("post_rst_pend", 32'(rd_pend), 32'h0);
      check("post_rst_valid", 32'(rd_valid), 32'h3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_nr_mw.md
REGFILE_NR_MW -- requirements
Module: regfile_nr_mw

Interface
REQ-001 SHALL have parameter XLEN, 32, data width in bits.
REQ-002 SHALL have parameter ADDR_W, 5, register index width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter N_RD, 2, read port count, legal 1..4.
REQ-004 SHALL have parameter N_WR, 1, write port count, legal 1..2.
REQ-005 SHALL have parameter ZERO_REG, 1; when 1, register 0 reads zero, is never written and is never pending.
REQ-006 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-007 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port rd_en  input  N_RD  per-port read request.
REQ-009 SHALL have port rd_addr  input  N_RD*ADDR_W  packed read indices, port p at [p*ADDR_W +: ADDR_W].
REQ-010 SHALL have port rd_data  output  N_RD*XLEN  packed registered read data.
REQ-011 SHALL have port rd_valid  output  N_RD  rd_data of port p is valid this cycle.
REQ-012 SHALL have port rd_pend  output  N_RD  pending bit of the addressed register, sampled with the read.
REQ-013 SHALL have port wr_en  input  N_WR  per-port write enable.
REQ-014 SHALL have port wr_addr  input  N_WR*ADDR_W  packed write indices.
REQ-015 SHALL have port wr_data  input  N_WR*XLEN  packed write data.
REQ-016 SHALL have port pend_set  input  1  mark register pend_addr as awaiting writeback.
REQ-017 SHALL have port pend_addr  input  ADDR_W  index to mark pending.

Function
REQ-018 SHALL register reads: rd_en[p] high in cycle N gives rd_data[p], rd_pend[p] and rd_valid[p]=1 in cycle N+1.
REQ-019 SHALL drive rd_valid[p]=0 and hold rd_data[p] and rd_pend[p] unchanged in the cycle after rd_en[p] is low.
REQ-020 SHALL commit wr_data[w] to wr_addr[w] at the clock edge when wr_en[w] is high.
REQ-021 SHALL bypass writes to reads (write-first): same-cycle read and write to the same index returns the new wr_data.
REQ-022 SHALL resolve two write ports targeting one index in the same cycle so that the higher-numbered port wins, for both storage and bypass.
REQ-023 SHALL clear a register's pending bit on any committed write to it.
REQ-024 SHALL set the pending bit of pend_addr when pend_set is high; same-cycle set and write to the same index leaves it set (set wins).
REQ-025 SHALL report rd_pend with the same write-first view: a same-cycle write clears it, and a same-cycle set on the read index reports 1.
REQ-026 SHALL, with ZERO_REG=1, ignore writes and pend_set to index 0 and return rd_data=0 and rd_pend=0 for reads of index 0, including under bypass.
REQ-027 SHALL, with ZERO_REG=0, treat index 0 as an ordinary register.

Reset
REQ-028 SHALL, while rst is low, asynchronously clear all registers, all pending bits, rd_data, rd_pend and rd_valid to 0.
REQ-029 SHALL discard any write, read or pend_set presented in the cycle rst deasserts only if rst is still low at that edge; the first edge with rst high operates normally.
REQ-030 SHALL abandon in-flight reads when reset asserts mid-operation, with no rd_valid pulse afterwards.

Structure
REQ-031 SHALL take XLEN/ADDR_W defaults and a write-merge function (priority-resolved data/hit for an index) from shared package regfile_pkg.
REQ-032 SHALL instantiate one sub-module regfile_rd_port per read port, containing the bypass mux and the output registers.
REQ-033 SHALL keep storage as a single array so it can be replaced by SRAM/BRAM with external bypass.

Verification
REQ-034 SHALL cover: write x5=0xDEADBEEF, next cycle read x5 on port 0 -> rd_data0=0xDEADBEEF, rd_valid0=1 one cycle later.
REQ-035 SHALL cover: same cycle write x7=0x1234 and read x7 on both ports -> both return 0x1234 (bypass).
REQ-036 SHALL cover: N_WR=2, both write x3 (0xA, 0xB) -> later read x3=0xB.
REQ-037 SHALL cover: pend_set x9, read x9 -> rd_pend=1; write x9 and pend_set x9 same cycle -> rd_pend stays 1; write only -> 0.
REQ-038 SHALL cover: write x0=0xFFFF and pend_set x0 -> read x0 returns 0, rd_pend 0 (ZERO_REG=1).
REQ-039 SHALL cover: assert rst mid-stream after filling x1..x31 -> all reads return 0, rd_valid 0 during reset, no stale valid afterwards.
